// File: rtl/piso_pkg.sv
// Shared types, sizing and frame-length helper for the PISO serial transmitter.
// Build option: define PISO_PARITY_EN to append an even-parity bit to every frame.
package piso_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits on the wire per frame: data bits, plus the parity bit when enabled.
    function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit-position counter for the PISO transmitter.
// Counts bit cycles within a frame and flags the final bit cycle (cnt == FRAME-1).
module piso_bit_counter #(
    parameter int FRAME = 8,
    parameter int CNT_W = $clog2(FRAME + 1)
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CNT_W'(FRAME - 1));

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out transmitter, LSB first, one bit per clk with back-to-back frames.
// Build option: PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CNT_W = $clog2(FRAME + 1);

    // Handshake: a word is taken on any rising edge where load && ready; din
    // is sampled only on that edge and a load seen while ready=0 is dropped.

    state_t           r_state;
    logic [WIDTH-2:0] r_shreg;
    logic             r_sout;
    logic             r_done;

    logic             w_shift;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_cnt_clear;
    logic             w_next_bit;
    logic [CNT_W-1:0] w_cnt;

    assign w_shift     = (r_state == S_SHIFT);
    assign w_ready     = !w_shift || w_last;
    assign w_accept    = load && w_ready;
    assign w_cnt_clear = rst || w_accept || (w_shift && w_last);

    piso_bit_counter #(
        .FRAME (FRAME),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .i_clear (w_cnt_clear),
        .i_en    (w_shift),
        .o_cnt   (w_cnt),
        .o_last  (w_last)
    );

`ifdef PISO_PARITY_EN
    logic r_parity;

    // After the last data bit the line carries the parity of the captured word.
    assign w_next_bit = (w_cnt == CNT_W'(WIDTH - 1)) ? r_parity : r_shreg[0];
`else
    logic w_cnt_unused;

    assign w_next_bit   = r_shreg[0];
    assign w_cnt_unused = ^w_cnt;
`endif

    // r_shreg holds the bits still to be sent; bit 0 goes straight to sout on capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_sout   <= 1'b0;
            r_done   <= 1'b0;
`ifdef PISO_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= w_shift && w_last;
            if (w_accept) begin
                r_state  <= S_SHIFT;
                r_shreg  <= din[WIDTH-1:1];
                r_sout   <= din[0];
`ifdef PISO_PARITY_EN
                r_parity <= ^din;
`endif
            end else if (w_shift && w_last) begin
                r_state <= S_IDLE;
                r_sout  <= 1'b0;
            end else if (w_shift) begin
                r_shreg <= r_shreg >> 1;
                r_sout  <= w_next_bit;
            end
        end
    end

    assign ready = w_ready;
    assign busy  = w_shift;
    assign sout  = r_sout;
    assign done  = r_done;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: bit-queue line model, SIPO word scoreboard, directed vectors.
// Honours PISO_PARITY_EN the same way the design does.
module tb_piso_shift_reg;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             sout;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    piso_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .load  (load),
        .ready (ready),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Line model: queue of bits still to appear on sout, head = bit on the line now.
    logic             m_q[$];
    logic             m_done = 1'b0;
    logic             chk_en = 1'b0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] rx_log[$];

    always @(posedge clk) begin
        logic acc;
        logic was_busy;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_done = 1'b0;
            chk_en = 1'b1;
        end else begin
            acc      = load && (m_q.size() <= 1);
            was_busy = (m_q.size() > 0);
            if (was_busy) void'(m_q.pop_front());
            m_done = was_busy && (m_q.size() == 0);
            if (acc) begin
                for (int k = 0; k < WIDTH; k++) m_q.push_back(din[k]);
`ifdef PISO_PARITY_EN
                m_q.push_back(^din);
`endif
                exp_q.push_back(din);
            end
        end
    end

    // Compare process: line-level outputs every cycle, plus a SIPO receiver scoreboard.
    logic [31:0] rx_bits = '0;
    int          rx_n    = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("sout",  sout,  (m_q.size() > 0) ? m_q[0] : 1'b0);
            check("ready", ready, (m_q.size() <= 1));
            check("busy",  busy,  (m_q.size() > 0));
            check("done",  done,  m_done);
            if (done) begin
                check("rx_len", rx_n, FRAME);
                if (exp_q.size() == 0) begin
                    check("rx_unexpected_word", 1, 0);
                end else begin
                    check("rx_word", rx_bits[WIDTH-1:0], exp_q.pop_front());
`ifdef PISO_PARITY_EN
                    check("rx_parity", rx_bits[WIDTH], ^rx_bits[WIDTH-1:0]);
`endif
                end
                rx_log.push_back(rx_bits[WIDTH-1:0]);
                rx_n    = 0;
                rx_bits = '0;
            end
            if (!busy) begin
                rx_n    = 0;
                rx_bits = '0;
            end else if (rx_n < 32) begin
                rx_bits[rx_n] = sout;
                rx_n++;
            end
        end
    end

    // driver: apply inputs for one cycle, return at the following negedge
    task automatic step(input logic r, input logic l, input logic [WIDTH-1:0] d);
        rst  = r;
        load = l;
        din  = d;
        @(negedge clk);
    endtask

    // load a word, then capture FRAME line bits and the ready pattern
    task automatic send_frame(input logic [WIDTH-1:0] d, output logic [31:0] bits,
                              output logic [31:0] rdy);
        bits = '0;
        rdy  = '0;
        step(1'b0, 1'b1, d);
        for (int k = 0; k < FRAME; k++) begin
            bits[k] = sout;
            rdy[k]  = ready;
            step(1'b0, 1'b0, '0);
        end
    endtask

    initial begin
        logic [31:0] bits;
        logic [31:0] rdy;
        logic [31:0] bz;
        int          nd;
        int          log0;

        rst  = 1'b1;
        load = 1'b0;
        din  = '0;

        // 1: reset and idle line
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("rst_sout", sout, 0);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (20) step(1'b0, 1'b0, '0);
        check("idle_sout", sout, 0);
        check("idle_ready", ready, 1);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // 2: single frame A5, LSB first
        send_frame(8'hA5, bits, rdy);
`ifdef PISO_PARITY_EN
        check("a5_bits", bits, 32'h0A5);
        check("a5_ready", rdy, 32'h100);
`else
        check("a5_bits", bits, 32'hA5);
        check("a5_ready", rdy, 32'h80);
`endif
        check("a5_done", done, 1);
        step(1'b0, 1'b0, '0);
        check("a5_done_pulse", done, 0);

        // 3: back-to-back 0F then 81
        bits = '0;
        bz   = '0;
        nd   = 0;
        step(1'b0, 1'b1, 8'h0F);
        for (int i = 0; i < 2 * FRAME; i++) begin
            bits[i] = sout;
            bz[i]   = busy;
            if (done) nd++;
            step(1'b0, (i == FRAME - 1), (i == FRAME - 1) ? 8'h81 : 8'h00);
        end
        if (done) nd++;
`ifdef PISO_PARITY_EN
        check("b2b_bits", bits, 32'h1020F);
        check("b2b_busy", bz, 32'h3FFFF);
`else
        check("b2b_bits", bits, 32'h810F);
        check("b2b_busy", bz, 32'hFFFF);
`endif
        check("b2b_done_count", nd, 2);
        step(1'b0, 1'b0, '0);
        check("b2b_idle_busy", busy, 0);

        // 4: reset in bit 3 of an FF frame, then a clean 01 frame
        step(1'b0, 1'b1, 8'hFF);
        repeat (3) step(1'b0, 1'b0, '0);
        check("mid_bit3", sout, 1);
        step(1'b1, 1'b0, '0);
        check("mid_rst_sout", sout, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_done", done, 0);
        step(1'b0, 1'b0, '0);
        check("mid_no_done", done, 0);
        send_frame(8'h01, bits, rdy);
`ifdef PISO_PARITY_EN
        check("post_rst_bits", bits, 32'h101);
`else
        check("post_rst_bits", bits, 32'h01);
`endif
        check("post_rst_done", done, 1);
        step(1'b0, 1'b0, '0);

        // 5: load held high with din changing every cycle
        log0 = rx_log.size();
        for (int i = 0; i <= 3 * FRAME; i++) begin
            step(1'b0, 1'b1, WIDTH'(32'h5A ^ (i * 32'h13)));
        end
        repeat (FRAME + 2) step(1'b0, 1'b0, '0);
        check("held_word_count", rx_log.size() - log0, 4);
        if (rx_log.size() - log0 == 4) begin
`ifdef PISO_PARITY_EN
            check("held_w0", rx_log[log0],     8'h5A);
            check("held_w1", rx_log[log0 + 1], 8'hF1);
            check("held_w2", rx_log[log0 + 2], 8'h0C);
            check("held_w3", rx_log[log0 + 3], 8'h5B);
`else
            check("held_w0", rx_log[log0],     8'h5A);
            check("held_w1", rx_log[log0 + 1], 8'hC2);
            check("held_w2", rx_log[log0 + 2], 8'h6A);
            check("held_w3", rx_log[log0 + 3], 8'h92);
`endif
        end

`ifdef PISO_PARITY_EN
        // 6: parity bit values
        send_frame(8'h07, bits, rdy);
        check("par07_bits", bits, 32'h107);
        check("par07_done", done, 1);
        step(1'b0, 1'b0, '0);
        send_frame(8'h03, bits, rdy);
        check("par03_bits", bits, 32'h003);
        check("par03_done", done, 1);
        step(1'b0, 1'b0, '0);
`endif

        repeat (2) step(1'b0, 1'b0, '0);
        check("words_outstanding", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
